rsa_job_sequencer: RTL and testbench
====================================

# rsa_job_sequencer

Hardware initiator for the RSA `control` core. It accepts RSA jobs (p, q, mode, message) over a valid/ready port and runs the core's two phases: inverter, then modular exponentiation. It returns the result over a second valid/ready port. It sits between a host/bus front end and `control`, and does in RTL what the directed benches do by hand with `reset_inverter`/`reset_mod_exp` pulses and finish polling.

## Interface
Parameters:
- `WIDTH`, 128, width of p and q; message width is 2*WIDTH.
- `TIMEOUT`, 65535, maximum wait cycles per phase before the job is aborted; must be ≥ 2. Counter is 32 bits.

Ports:
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — synchronous, active-high.
- `job_valid` input 1 — job request valid.
- `job_ready` output 1 — sequencer can accept a job.
- `job_p` input WIDTH — prime p.
- `job_q` input WIDTH — prime q.
- `job_mode` input 1 — 0 = encrypt, 1 = decrypt; drives `encrypt_decrypt`.
- `job_msg` input 2*WIDTH — message.
- `ctl_p` output WIDTH — to `control` p.
- `ctl_q` output WIDTH — to `control` q.
- `ctl_encrypt_decrypt` output 1 — to `control`.
- `ctl_msg_in` output 2*WIDTH — to `control`.
- `ctl_reset_inverter` output 1 — one-cycle start pulse for the inverter phase.
- `ctl_reset_mod_exp` output 1 — one-cycle start pulse for the mod_exp phase.
- `ctl_inverter_finish` input 1 — from `control`.
- `ctl_mod_exp_finish` input 1 — from `control`.
- `ctl_msg_out` input 2*WIDTH — from `control`.
- `res_valid` output 1 — result valid; held until accepted.
- `res_ready` input 1 — consumer accepts the result.
- `res_msg` output 2*WIDTH — captured `ctl_msg_out`.
- `res_error` output 1 — job aborted by timeout; `res_msg` = 0.
- `res_key_reused` output 1 — inverter phase skipped (key cache hit).
- `busy` output 1 — state ≠ IDLE.

## Operation
- States: IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, DONE.
- IDLE:
  - `job_ready` = 1.
  - On `job_valid`: register `job_p`, `job_q`, `job_mode` and `job_msg` into the `ctl_*` outputs.
  - If `key_valid` is set and `job_p`/`job_q` equal the cached p/q, go to EXP_PULSE with reused = 1. Otherwise go to INV_PULSE with reused = 0.
- INV_PULSE: `ctl_reset_inverter` = 1 for exactly this cycle, then INV_WAIT with the wait counter cleared.
- INV_WAIT:
  - The counter increments every cycle.
  - `ctl_inverter_finish` is ignored while counter = 0, which masks a stale finish from the previous job.
  - When finish = 1 and counter ≥ 1: set `key_valid`, cache p/q, go to EXP_PULSE.
  - When counter = TIMEOUT−1 with no finish: error = 1, clear `key_valid`, go to DONE.
- EXP_PULSE: `ctl_reset_mod_exp` = 1 for exactly this cycle, then EXP_WAIT with the counter cleared.
- EXP_WAIT:
  - Same masking and timeout rules, applied to `ctl_mod_exp_finish`.
  - On finish: capture `ctl_msg_out` into `res_msg`, error = 0, go to DONE.
  - On timeout: `res_msg` = 0, error = 1, clear `key_valid`.
- DONE:
  - `res_valid` = 1; `res_msg`, `res_error` and `res_key_reused` are stable.
  - On `res_ready`, go to IDLE.
- Inputs are ignored while not in IDLE; `job_ready` = 0 there.
- `ctl_p`, `ctl_q`, `ctl_encrypt_decrypt` and `ctl_msg_in` change only at job acceptance, and stay stable through both phases and DONE.
- The cache key is p and q only. Mode and message changes do not force an inverter rerun.
- `reset` (any state, including mid-phase):
  - State goes to IDLE.
  - All outputs go to 0, except `job_ready`, which is 1 from the first cycle after reset.
  - `key_valid` is cleared.
  - No start pulse is issued during or in the cycle after reset.

## Timing
- Reset values: all outputs 0 except `job_ready` = 1, as above.
- Acceptance: at the edge where `job_valid` & `job_ready` in cycle A. `ctl_*` data is valid from A+1, and the start pulse is high in cycle A+1.
- Finish sampling: a finish first seen high in wait-cycle index k ≥ 1 gives the next start pulse in the following cycle. Mod_exp finish gives `res_valid` in the following cycle.
- Minimum latency, acceptance to `res_valid`:
  - no cache hit: 6 cycles (finish seen in wait cycle 1 for both phases);
  - cache hit: 3 cycles.
- Result handshake: with `res_ready` held high, DONE lasts 1 cycle. The next `job_ready` = 1 follows in the cycle after. Back-to-back throughput is one job per (latency + 2) cycles.
- Timeout: abort at exactly TIMEOUT wait cycles per phase.
- `ctl_reset_*` are never high in the same cycle; each pulse is exactly 1 cycle wide.

## Test plan
- Encrypt, no cache:
  - Stimulus: p=113680897410347, q=7999808077935876437321, mode=0, msg=0x2d806a3e18f03ab37b2800000000; behavioural `control` model with finish after 5 cycles.
  - Response: one `ctl_reset_inverter` pulse, then one `ctl_reset_mod_exp` pulse; `res_msg` equals the model output; `res_key_reused`=0; `res_error`=0.
- Cache hit:
  - Stimulus: same p/q again, mode=1, msg = the previous result.
  - Response: no inverter pulse; `res_key_reused`=1; `res_msg`=0x2d806a3e18f03ab37b2800000000 (round-trip); latency 3 cycles with the model finishing at wait cycle 1.
- Swapped key:
  - Stimulus: p=7999808077935876437321, q=113680897410347.
  - Response: cache miss, inverter phase rerun, `res_key_reused`=0.
- Stale finish:
  - Stimulus: model holds `mod_exp_finish`=1 until 2 cycles after the start pulse.
  - Response: the sequencer does not capture in wait cycle 0; it captures on the fresh finish.
- Timeout:
  - Stimulus: TIMEOUT=8; model never asserts `inverter_finish`.
  - Response: `res_valid` with `res_error`=1 and `res_msg`=0 after exactly 8 wait cycles; the next identical job reruns the inverter.
- Backpressure and reset:
  - Stimulus: hold `res_ready`=0 for 10 cycles.
  - Response: `res_*` stable and `job_ready`=0 throughout.
  - Stimulus: assert `reset` in EXP_WAIT.
  - Response: next cycle IDLE, all outputs 0 except `job_ready`=1, no pulses, cache cleared.

Source files
------------

// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: accepts RSA jobs, runs the inverter then mod_exp phases of
// the `control` core with one-cycle start pulses, and returns the result over a
// valid/ready port. A one-entry p/q cache skips the inverter when the key repeats.
module rsa_job_sequencer #(
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [WIDTH-1:0]   job_p,
    input  logic [WIDTH-1:0]   job_q,
    input  logic               job_mode,
    input  logic [2*WIDTH-1:0] job_msg,
    output logic [WIDTH-1:0]   ctl_p,
    output logic [WIDTH-1:0]   ctl_q,
    output logic               ctl_encrypt_decrypt,
    output logic [2*WIDTH-1:0] ctl_msg_in,
    output logic               ctl_reset_inverter,
    output logic               ctl_reset_mod_exp,
    input  logic               ctl_inverter_finish,
    input  logic               ctl_mod_exp_finish,
    input  logic [2*WIDTH-1:0] ctl_msg_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_msg,
    output logic               res_error,
    output logic               res_key_reused,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        INV_PULSE,
        INV_WAIT,
        EXP_PULSE,
        EXP_WAIT,
        DONE
    } state_t;

    // Last wait-cycle index of a phase; reaching it without finish aborts.
    localparam logic [31:0] LAST_WAIT = 32'(TIMEOUT - 1);

    state_t             state, state_nx;
    logic [31:0]        wait_cnt;
    logic               key_valid;
    logic [WIDTH-1:0]   key_p, key_q;
    logic               key_hit;
    logic               inv_done, exp_done, timed_out;

    // Phase events; wait cycle 0 ignores finish so a level left high by the
    // previous job cannot be mistaken for completion.
    always_comb begin
        key_hit   = key_valid && (job_p == key_p) && (job_q == key_q);
        inv_done  = (state == INV_WAIT) && ctl_inverter_finish && (wait_cnt != 32'd0);
        exp_done  = (state == EXP_WAIT) && ctl_mod_exp_finish && (wait_cnt != 32'd0);
        timed_out = (wait_cnt == LAST_WAIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nx           = state;
        job_ready          = 1'b0;
        busy               = 1'b1;
        res_valid          = 1'b0;
        ctl_reset_inverter = 1'b0;
        ctl_reset_mod_exp  = 1'b0;
        unique case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) state_nx = key_hit ? EXP_PULSE : INV_PULSE;
            end
            INV_PULSE: begin
                ctl_reset_inverter = !reset;
                state_nx           = INV_WAIT;
            end
            INV_WAIT: begin
                if (inv_done)       state_nx = EXP_PULSE;
                else if (timed_out) state_nx = DONE;
            end
            EXP_PULSE: begin
                ctl_reset_mod_exp = !reset;
                state_nx          = EXP_WAIT;
            end
            EXP_WAIT: begin
                if (exp_done || timed_out) state_nx = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Job registers, wait counter, key cache and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_p               <= '0;
            ctl_q               <= '0;
            ctl_encrypt_decrypt <= 1'b0;
            ctl_msg_in          <= '0;
            wait_cnt            <= '0;
            key_valid           <= 1'b0;
            key_p               <= '0;
            key_q               <= '0;
            res_msg             <= '0;
            res_error           <= 1'b0;
            res_key_reused      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (job_valid) begin
                        ctl_p               <= job_p;
                        ctl_q               <= job_q;
                        ctl_encrypt_decrypt <= job_mode;
                        ctl_msg_in          <= job_msg;
                        res_key_reused      <= key_hit;
                    end
                end
                INV_PULSE, EXP_PULSE: begin
                    wait_cnt <= '0;
                end
                INV_WAIT: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (inv_done) begin
                        key_valid <= 1'b1;
                        key_p     <= ctl_p;
                        key_q     <= ctl_q;
                    end else if (timed_out) begin
                        key_valid <= 1'b0;
                        res_msg   <= '0;
                        res_error <= 1'b1;
                    end
                end
                EXP_WAIT: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (exp_done) begin
                        res_msg   <= ctl_msg_out;
                        res_error <= 1'b0;
                    end else if (timed_out) begin
                        key_valid <= 1'b0;
                        res_msg   <= '0;
                        res_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer: behavioural `control` stand-in (result is
// msg ^ {p,q}, an involution so encrypt/decrypt round-trips), a job-level
// reference model for latency/result/cache, and a per-cycle output monitor.
module tb_rsa_job_sequencer;
    localparam int W  = 128;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           job_valid = 1'b0;
    logic           job_ready;
    logic [W-1:0]   job_p = '0, job_q = '0;
    logic           job_mode = 1'b0;
    logic [2*W-1:0] job_msg = '0;
    logic [W-1:0]   ctl_p, ctl_q;
    logic           ctl_encrypt_decrypt;
    logic [2*W-1:0] ctl_msg_in;
    logic           ctl_reset_inverter, ctl_reset_mod_exp;
    logic           ctl_inverter_finish = 1'b0, ctl_mod_exp_finish = 1'b0;
    logic [2*W-1:0] ctl_msg_out = '0;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [2*W-1:0] res_msg;
    logic           res_error, res_key_reused, busy;

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_p(job_p), .job_q(job_q), .job_mode(job_mode), .job_msg(job_msg),
        .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_encrypt_decrypt(ctl_encrypt_decrypt),
        .ctl_msg_in(ctl_msg_in), .ctl_reset_inverter(ctl_reset_inverter),
        .ctl_reset_mod_exp(ctl_reset_mod_exp), .ctl_inverter_finish(ctl_inverter_finish),
        .ctl_mod_exp_finish(ctl_mod_exp_finish), .ctl_msg_out(ctl_msg_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_msg(res_msg),
        .res_error(res_error), .res_key_reused(res_key_reused), .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0, nfail = 0;

    task automatic chk(input string nm, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Control stand-in settings and the current job as the bench sees it.
    int             inv_dly = 1, exp_dly = 1;
    bit             stale = 0;
    int             ti = -2, te = -2;
    bit             in_job = 0;
    int             inv_cnt = 0, exp_cnt = 0;
    logic [W-1:0]   cur_p, cur_q;
    logic           cur_mode;
    logic [2*W-1:0] cur_msg;

    // Job-level reference model state: one cached key.
    bit             kv = 0;
    logic [W-1:0]   kp, kq;
    int             last_lat, last_err, last_reused;
    logic [2*W-1:0] last_msg;

    // Behavioural `control`: finish is a level that rises at wait-cycle index
    // dly and stays high until the next start pulse. In stale mode mod_exp
    // finish stays high with an old result through the pulse and wait cycle 0.
    always @(negedge clk) begin
        if (ctl_reset_inverter) begin
            ti = -1;
            ctl_inverter_finish = 1'b0;
        end else if (ti > -2) begin
            ti++;
            if (ti >= inv_dly) ctl_inverter_finish = 1'b1;
        end
        if (ctl_reset_mod_exp) begin
            te = -1;
            if (stale) begin
                ctl_mod_exp_finish = 1'b1;
                ctl_msg_out = ~(ctl_msg_in ^ {ctl_p, ctl_q});
            end else begin
                ctl_mod_exp_finish = 1'b0;
            end
        end else if (te > -2) begin
            te++;
            if (te >= (stale ? 1 : exp_dly)) begin
                ctl_mod_exp_finish = 1'b1;
                ctl_msg_out = ctl_msg_in ^ {ctl_p, ctl_q};
            end
        end
    end

    // Per-cycle monitor: pulse exclusivity, and while a job is in flight the
    // ctl_* bus holds the accepted job and the port refuses new work.
    always @(negedge clk) begin
        if (!reset) chk("pulse_excl", int'(ctl_reset_inverter & ctl_reset_mod_exp), 0);
        if (in_job) begin
            chkw("ctl_p", 256'(ctl_p), 256'(cur_p));
            chkw("ctl_q", 256'(ctl_q), 256'(cur_q));
            chk("ctl_mode", int'(ctl_encrypt_decrypt), int'(cur_mode));
            chkw("ctl_msg_in", ctl_msg_in, cur_msg);
            chk("busy_job", int'(busy), 1);
            chk("job_ready_busy", int'(job_ready), 0);
            if (ctl_reset_inverter) inv_cnt++;
            if (ctl_reset_mod_exp)  exp_cnt++;
        end
    end

    task automatic accept(input logic [W-1:0] p, input logic [W-1:0] q,
                          input logic m, input logic [2*W-1:0] msg, output bit ok);
        int n = 0;
        ok = 1;
        @(negedge clk);
        while (!job_ready && n < 40) begin @(negedge clk); n++; end
        if (!job_ready) begin chk("job_ready_wait", 0, 1); ok = 0; return; end
        job_valid = 1'b1; job_p = p; job_q = q; job_mode = m; job_msg = msg;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        cur_p = p; cur_q = q; cur_mode = m; cur_msg = msg;
        inv_cnt = 0; exp_cnt = 0;
        in_job = 1;
    endtask

    task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic m,
                           input logic [2*W-1:0] msg, input int idly, input int edly,
                           input bit stl, input int hold);
        bit reused, err, ok;
        int ki, ke, lat, e_inv, e_exp, n;
        logic [2*W-1:0] e_res;
        // Reference model: wait-cycle index where finish is first honoured.
        reused = kv && (p == kp) && (q == kq);
        ki = (idly < 1) ? 1 : idly;
        ke = stl ? 1 : ((edly < 1) ? 1 : edly);
        err = 0; e_inv = reused ? 0 : 1; e_exp = 1;
        if (reused) begin
            if (ke <= TO - 1) lat = ke + 2;
            else begin lat = 1 + TO; err = 1; kv = 0; end
        end else if (ki > TO - 1) begin
            lat = 1 + TO; err = 1; kv = 0; e_exp = 0;
        end else begin
            kv = 1; kp = p; kq = q;
            if (ke <= TO - 1) lat = ki + ke + 4;
            else begin lat = ki + 3 + TO; err = 1; kv = 0; end
        end
        e_res = err ? '0 : (msg ^ {p, q});

        inv_dly = idly; exp_dly = edly; stale = stl;
        res_ready = (hold == 0);
        accept(p, q, m, msg, ok);
        if (!ok) return;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            job_valid = 1'($urandom_range(0, 1));
            job_p = ~p; job_q = ~q; job_mode = ~m; job_msg = ~msg;
        end while (!res_valid && n < 200);
        job_valid = 1'b0;
        if (!res_valid) begin chk("res_valid_wait", 0, 1); in_job = 0; return; end
        last_lat = n - 1; last_msg = res_msg;
        last_err = int'(res_error); last_reused = int'(res_key_reused);
        chk("latency", last_lat, lat);
        chkw("res_msg", res_msg, e_res);
        chk("res_error", last_err, int'(err));
        chk("res_key_reused", last_reused, int'(reused));
        chk("inv_pulses", inv_cnt, e_inv);
        chk("exp_pulses", exp_cnt, e_exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_res_valid", int'(res_valid), 1);
            chkw("bp_res_msg", res_msg, e_res);
            chk("bp_res_error", int'(res_error), int'(err));
            chk("bp_res_reused", int'(res_key_reused), int'(reused));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        in_job = 0;
        @(negedge clk);
        chk("job_ready_after", int'(job_ready), 1);
        chk("res_valid_after", int'(res_valid), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_job_ready"}, int'(job_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_pulses"}, int'({ctl_reset_inverter, ctl_reset_mod_exp}), 0);
        chkw({tag, "_ctl"}, 256'({ctl_p, ctl_q}), '0);
        chkw({tag, "_ctl_msg"}, ctl_msg_in, '0);
        chk({tag, "_mode"}, int'(ctl_encrypt_decrypt), 0);
        chkw({tag, "_res_msg"}, res_msg, '0);
        chk({tag, "_res_flags"}, int'({res_error, res_key_reused}), 0);
    endtask

    localparam logic [W-1:0]   P1 = 128'd113680897410347;
    localparam logic [W-1:0]   Q1 = 128'd7999808077935876437321;
    localparam logic [2*W-1:0] M1 = 256'h2d806a3e18f03ab37b2800000000;

    initial begin
        logic [W-1:0]   pool [3];
        logic [2*W-1:0] r1;
        bit ok;
        pool[0] = P1; pool[1] = Q1; pool[2] = 128'd1000003;

        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Encrypt, cold cache, finish at wait cycle 5 in both phases.
        run_job(P1, Q1, 1'b0, M1, 5, 5, 0, 0);
        chk("t1_lat_pin", last_lat, 14);
        chk("t1_reused_pin", last_reused, 0);
        r1 = last_msg;

        // Decrypt with same key: cache hit, round trip back to M1.
        run_job(P1, Q1, 1'b1, r1, 1, 1, 0, 0);
        chk("t2_lat_pin", last_lat, 3);
        chkw("t2_msg_pin", last_msg, M1);
        chk("t2_reused_pin", last_reused, 1);

        // Swapped p/q is a different key.
        run_job(Q1, P1, 1'b0, M1, 1, 1, 0, 0);
        chk("t3_lat_pin", last_lat, 6);
        chk("t3_reused_pin", last_reused, 0);

        // Stale mod_exp finish held across pulse and wait cycle 0.
        run_job(Q1, P1, 1'b0, M1 ^ 256'd1, 1, 0, 1, 0);
        chkw("t4_msg_pin", last_msg, (M1 ^ 256'd1) ^ {Q1, P1});
        chk("t4_lat_pin", last_lat, 3);

        // Inverter never finishes: abort after exactly TO wait cycles.
        run_job(P1, Q1, 1'b0, M1, 100, 1, 0, 0);
        chk("t5_lat_pin", last_lat, 9);
        chk("t5_err_pin", last_err, 1);
        chkw("t5_msg_pin", last_msg, '0);
        run_job(P1, Q1, 1'b0, M1, 1, 1, 0, 0);
        chk("t5b_reused_pin", last_reused, 0);

        // Result backpressure for 10 cycles.
        run_job(P1, Q1, 1'b1, M1, 1, 2, 0, 10);
        chk("t6_reused_pin", last_reused, 1);

        // Reset in EXP_WAIT of a cache-hit job.
        exp_dly = 6; stale = 0;
        accept(P1, Q1, 1'b0, M1, ok);
        repeat (3) @(negedge clk);
        in_job = 0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs("midreset");
        @(negedge clk);
        chk("midreset_nopulse", int'({ctl_reset_inverter, ctl_reset_mod_exp}), 0);
        kv = 0;
        run_job(P1, Q1, 1'b0, M1, 1, 1, 0, 0);
        chk("t7_reused_pin", last_reused, 0);

        // Randomized jobs over a small key pool to mix hits, misses, timeouts.
        for (int i = 0; i < 40; i++) begin
            run_job(pool[$urandom_range(0, 2)], pool[$urandom_range(0, 2)],
                    1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
